ft245_dev: RTL and testbench

Device-side counterpart of the FT245-style byte FIFO bus. It presents `rxf`/`txe` status, answers host `rd` strobes by driving bytes, and captures bytes on host `wr` strobes. Each direction has an internal FIFO, and the FPGA side uses toggle seq/ack byte streams. It is used as a simulation model of the USB bridge and as the responder when two boards are linked over the parallel FIFO bus.

---
 rtl/ft245_pkg.sv | 5 +
 rtl/byte_fifo.sv | 39 +++
 rtl/ft245_dev.sv | 104 ++++++++++
 tb/tb_ft245_dev.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ft245_pkg.sv
// ft245_pkg: shared types for the FT245-style FIFO bus responder
package ft245_pkg;
  typedef enum logic [1:0] {R_IDLE, R_DRIVE, R_HOLD} rstate_t;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO; caller never pushes when full or pops when empty
module byte_fifo
  import ft245_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  byte_t                  din,
  output byte_t                  dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  byte_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] count_q;
  assign dout  = mem_q[rp_q];
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  // storage, no reset: pointers define which entries are live
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= din;
  // pointers wrap naturally at DEPTH; count tracks simultaneous push and pop
  always_ff @(posedge clk)
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_q + AW'(push);
      rp_q    <= rp_q + AW'(pop);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/ft245_dev.sv
// ft245_dev: FT245-style bus responder with toggle seq/ack user streams; FT245_DEV_SIWU_EN gates host bytes on siwu
module ft245_dev
  import ft245_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       rxf,
  output logic       txe,
  input  logic       rd,
  input  logic       wr,
  input  logic       siwu,
  output logic [7:0] down_data,
  output logic       down_seq,
  input  logic       down_ack,
  input  logic [7:0] up_data,
  input  logic       up_seq,
  output logic       up_ack,
  output logic       proto_err
);
  localparam int AW = $clog2(DEPTH);
  rstate_t state_q;
  byte_t bus_out_q, down_data_q, up_head, dn_head;
  logic rd_ok_q, proto_err_q, up_ack_q, down_seq_q, txe_q;
  logic up_full, up_empty, dn_full;
  logic unused_dn_empty;
  logic [AW:0] unused_up_count, dn_count, dn_cnt_d, pending_q, pending_d, dn_vis;
  logic up_push, up_pop, dn_push, dn_pop, rd_err, wr_err;
  assign up_push = (up_seq != up_ack_q) && !up_full;
  assign up_pop  = (state_q == R_HOLD) && rd_ok_q;
  assign dn_push = wr && !rd && (state_q == R_IDLE) && !dn_full;
  assign dn_vis  = dn_count - pending_q;
  assign dn_pop  = (down_seq_q == down_ack) && (dn_vis != '0);
  assign dn_cnt_d = dn_count + (AW+1)'(dn_push) - (AW+1)'(dn_pop);
  assign rd_err  = (state_q == R_IDLE) && rd && (wr || up_empty);
  assign wr_err  = wr && ((state_q != R_IDLE) || rd || dn_full);
`ifdef FT245_DEV_SIWU_EN
  assign pending_d = siwu ? '0 : pending_q + (AW+1)'(dn_push);
`else
  logic unused_siwu;
  assign unused_siwu = siwu;
  assign pending_d = '0;
`endif
  assign bus_out   = bus_out_q;
  assign bus_oe    = state_q != R_IDLE;
  assign rxf       = (state_q == R_IDLE) && !up_empty;
  assign txe       = txe_q;
  assign down_data = down_data_q;
  assign down_seq  = down_seq_q;
  assign up_ack    = up_ack_q;
  assign proto_err = proto_err_q;
  byte_fifo #(.DEPTH(DEPTH)) u_up (
    .clk(clk), .reset(reset), .push(up_push), .pop(up_pop), .din(up_data),
    .dout(up_head), .full(up_full), .empty(up_empty), .count(unused_up_count)
  );
  byte_fifo #(.DEPTH(DEPTH)) u_dn (
    .clk(clk), .reset(reset), .push(dn_push), .pop(dn_pop), .din(bus_in),
    .dout(dn_head), .full(dn_full), .empty(unused_dn_empty), .count(dn_count)
  );
  // read FSM: latch head on rd, drive while rd held, one hold cycle, then pop if a real byte was sent
  always_ff @(posedge clk)
    if (reset) begin
      state_q     <= R_IDLE;
      bus_out_q   <= '0;
      rd_ok_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_q | rd_err | wr_err;
      case (state_q)
        R_IDLE: if (rd && !wr) begin
          state_q   <= R_DRIVE;
          bus_out_q <= up_empty ? 8'h00 : up_head;
          rd_ok_q   <= !up_empty;
        end
        R_DRIVE: if (!rd) state_q <= R_HOLD;
        R_HOLD:  state_q <= R_IDLE;
        default: state_q <= R_IDLE;
      endcase
    end
  // user side: accept up requests and hand visible down bytes to the toggle stream
  always_ff @(posedge clk)
    if (reset) begin
      up_ack_q    <= 1'b0;
      down_seq_q  <= 1'b0;
      down_data_q <= '0;
    end else begin
      up_ack_q    <= up_push ? up_seq : up_ack_q;
      down_seq_q  <= down_seq_q ^ dn_pop;
      down_data_q <= dn_pop ? dn_head : down_data_q;
    end
  // txe from next down count so a write shows the following cycle; pending holds uncommitted bytes
  always_ff @(posedge clk)
    if (reset) begin
      txe_q     <= 1'b0;
      pending_q <= '0;
    end else begin
      txe_q     <= dn_cnt_d != (AW+1)'(DEPTH);
      pending_q <= pending_d;
    end
endmodule

// File: tb/tb_ft245_dev.sv
// tb_ft245_dev: directed bench with a down-stream scoreboard and direct bus checks
module tb_ft245_dev;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] bus_in = '0, up_data = '0;
  logic rd = 1'b0, wr = 1'b0, siwu = 1'b0, up_seq = 1'b0, down_ack = 1'b0;
  logic [7:0] bus_out, down_data;
  logic bus_oe, rxf, txe, down_seq, up_ack, proto_err;
  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic ack_en = 1'b0;
  logic last_seq;
  logic [7:0] e;
  ft245_dev #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .rxf(rxf), .txe(txe), .rd(rd), .wr(wr), .siwu(siwu), .down_data(down_data),
    .down_seq(down_seq), .down_ack(down_ack), .up_data(up_data), .up_seq(up_seq),
    .up_ack(up_ack), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1; rd = 1'b0; wr = 1'b0; siwu = 1'b0; up_seq = 1'b0; ack_en = 1'b0;
    step(2);
    reset = 1'b0;
    step();
  endtask
  // monitor: every down_seq toggle must deliver the next expected byte; acks when enabled
  initial begin
    last_seq = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_seq = 1'b0;
        down_ack = 1'b0;
      end else begin
        if (down_seq != last_seq) begin
          last_seq = down_seq;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL down_unexpected got=%h exp=none", down_data);
          end else begin
            e = exp_q.pop_front();
            if (down_data !== e) begin
              failures++;
              $display("FAIL down_byte got=%h exp=%h", down_data, e);
            end
          end
        end
        if (ack_en && down_ack != down_seq) down_ack = down_seq;
      end
    end
  end
  initial begin
    step(2);
    chk("rst_bus_oe", {7'd0, bus_oe}, 8'd0);
    chk("rst_bus_out", bus_out, 8'h00);
    chk("rst_rxf", {7'd0, rxf}, 8'd0);
    chk("rst_txe", {7'd0, txe}, 8'd0);
    chk("rst_down", {down_data[6:0], down_seq}, 8'd0);
    chk("rst_up_ack", {7'd0, up_ack}, 8'd0);
    chk("rst_err", {7'd0, proto_err}, 8'd0);
    reset = 1'b0;
    step();
    chk("txe_after_rst", {7'd0, txe}, 8'd1);
    // user push then 2-cycle host read
    up_data = 8'hA5; up_seq = 1'b1;
    step();
    chk("up_ack_next", {7'd0, up_ack}, 8'd1);
    step();
    chk("rxf_up", {7'd0, rxf}, 8'd1);
    rd = 1'b1;
    step();
    chk("rd1_oe", {7'd0, bus_oe}, 8'd1);
    chk("rd1_out", bus_out, 8'hA5);
    chk("rd1_rxf", {7'd0, rxf}, 8'd0);
    step();
    rd = 1'b0;
    chk("rd2_oe", {7'd0, bus_oe}, 8'd1);
    chk("rd2_out", bus_out, 8'hA5);
    step();
    chk("rd3_oe", {7'd0, bus_oe}, 8'd1);
    chk("rd3_out", bus_out, 8'hA5);
    step();
    chk("rd_end_oe", {7'd0, bus_oe}, 8'd0);
    chk("rd_end_rxf", {7'd0, rxf}, 8'd0);
    chk("rd_no_err", {7'd0, proto_err}, 8'd0);
    // read with empty up FIFO
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("empty_rd_out", bus_out, 8'h00);
    chk("empty_rd_err", {7'd0, proto_err}, 8'd1);
    step(3);
    chk("empty_rd_rxf", {7'd0, rxf}, 8'd0);
    up_data = 8'h11; up_seq = 1'b0;
    step(2);
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("after_empty_out", bus_out, 8'h11);
    step(3);
    chk("after_empty_rxf", {7'd0, rxf}, 8'd0);
    // single host write delivered downstream, left unacked
    do_reset();
    siwu = 1'b1;
    bus_in = 8'h3C; wr = 1'b1; exp_q.push_back(8'h3C);
    step();
    wr = 1'b0;
    chk("wr1_seq_early", {7'd0, down_seq}, 8'd0);
    step();
    chk("wr1_seq", {7'd0, down_seq}, 8'd1);
    chk("wr1_data", down_data, 8'h3C);
    // fill the down FIFO
    for (int i = 0; i < 16; i++) begin
      bus_in = 8'h40 + 8'(i); wr = 1'b1; exp_q.push_back(bus_in);
      step();
    end
    wr = 1'b0;
    chk("full_txe", {7'd0, txe}, 8'd0);
    chk("full_no_err", {7'd0, proto_err}, 8'd0);
    bus_in = 8'hEE; wr = 1'b1;
    step();
    wr = 1'b0;
    chk("overflow_err", {7'd0, proto_err}, 8'd1);
    ack_en = 1'b1;
    step(40);
    chk("drain_left", 8'(exp_q.size()), 8'd0);
    chk("drain_txe", {7'd0, txe}, 8'd1);
    siwu = 1'b0;
`ifdef FT245_DEV_SIWU_EN
    do_reset();
    ack_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus_in = 8'(i); wr = 1'b1; exp_q.push_back(bus_in);
      step();
    end
    wr = 1'b0;
    step(3);
    chk("siwu_hold", {7'd0, down_seq}, 8'd0);
    siwu = 1'b1;
    step();
    siwu = 1'b0;
    step(8);
    chk("siwu_left", 8'(exp_q.size()), 8'd0);
`endif
    // reset during an active read
    do_reset();
    up_data = 8'h77; up_seq = 1'b1;
    step(2);
    rd = 1'b1;
    step();
    chk("mid_oe", {7'd0, bus_oe}, 8'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_oe", {7'd0, bus_oe}, 8'd0);
    chk("mid_rst_rxf", {7'd0, rxf}, 8'd0);
    reset = 1'b0; rd = 1'b0; up_seq = 1'b0;
    step();
    chk("post_rst_txe", {7'd0, txe}, 8'd1);
    chk("post_rst_rxf", {7'd0, rxf}, 8'd0);
    chk("post_rst_oe", {7'd0, bus_oe}, 8'd0);
    step(2);
    chk("post_rst_rxf2", {7'd0, rxf}, 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
